// File: rtl/id_stage_pkg.sv
// Decode constants and small helpers shared by the RV32I decode/issue stage.
package id_stage_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int REG_NUM_DEF = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [1:0] {
    CLS_OP,
    CLS_OPIMM,
    CLS_ILLEGAL
  } inst_cls_t;

  function automatic inst_cls_t classify(input logic [6:0] opcode);
    inst_cls_t cls;
    case (opcode)
      OPC_OP:    cls = CLS_OP;
      OPC_OPIMM: cls = CLS_OPIMM;
      default:   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // OP-IMM only carries funct7 for shifts, where it selects logical/arithmetic.
  function automatic logic [6:0] dec_funct7(input inst_cls_t cls,
                                            input logic [2:0] f3,
                                            input logic [6:0] f7);
    logic [6:0] res;
    res = f7;
    if (cls == CLS_OPIMM && f3 != F3_SLL && f3 != F3_SRL_SRA) begin
      res = 7'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side and execute-side valid/ready bundles of the decode/issue stage.
interface id_stage_if
  import id_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5
);

  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;

  logic            ex_valid;
  logic            ex_ready;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [AW-1:0]   ex_rd_addr;
  logic            ex_rd_we;
  logic [XLEN-1:0] ex_pc;
  logic            ex_illegal;

  modport master (
    input  if_valid, if_inst, if_pc, ex_ready,
    output if_ready, ex_valid, ex_opcode, ex_funct3, ex_funct7,
           ex_rs1, ex_rs2, ex_rd_addr, ex_rd_we, ex_pc, ex_illegal
  );

  modport slave (
    output if_valid, if_inst, if_pc, ex_ready,
    input  if_ready, ex_valid, ex_opcode, ex_funct3, ex_funct7,
           ex_rs1, ex_rs2, ex_rd_addr, ex_rd_we, ex_pc, ex_illegal
  );

endinterface

// File: rtl/id_stage_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
module id_stage_scoreboard
  import id_stage_pkg::*;
#(
  parameter  int REG_NUM = REG_NUM_DEF,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          q1_busy,
  output logic          q2_busy
);

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_n;

  // Set is applied after clear so a same-cycle issue of a new writer wins.
  always_comb begin
    busy_n = busy_q;
    if (clr_en) begin
      busy_n[clr_addr] = 1'b0;
    end
    if (set_en) begin
      busy_n[set_addr] = 1'b1;
    end
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_n;
    end
  end

  assign q1_busy = busy_q[q1_addr];
  assign q2_busy = busy_q[q2_addr];

endmodule

// File: rtl/id_stage.sv
// RV32I decode/issue stage: operand read with writeback bypass, RAW stall on
// the scoreboard or the output register, registered bundle towards the ALU.
module id_stage
  import id_stage_pkg::*;
#(
  parameter  int XLEN    = XLEN_DEF,
  parameter  int REG_NUM = REG_NUM_DEF,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic            clk,
  input  logic            rst_n,
  id_stage_if.master      bus,
  output logic [AW-1:0]   rf_raddr1,
  output logic [AW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  // ---- p0: decode of the instruction presented by fetch
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [6:0]             funct7;
  logic [AW-1:0]          rs1_a;
  logic [AW-1:0]          rs2_a;
  logic [AW-1:0]          rd_a;
  logic signed [11:0]     imm12;
  logic signed [XLEN-1:0] imm_sx;
  inst_cls_t              cls;

  assign opcode = bus.if_inst[6:0];
  assign rd_a   = bus.if_inst[11:7];
  assign funct3 = bus.if_inst[14:12];
  assign rs1_a  = bus.if_inst[19:15];
  assign rs2_a  = bus.if_inst[24:20];
  assign imm12  = bus.if_inst[31:20];
  assign imm_sx = XLEN'(imm12);
  assign cls    = classify(opcode);
  assign funct7 = dec_funct7(cls, funct3, bus.if_inst[31:25]);

  assign rf_raddr1 = rs1_a;
  assign rf_raddr2 = rs2_a;

  logic use1, use2, rd_we;
  assign use1  = (cls != CLS_ILLEGAL) && (rs1_a != '0);
  assign use2  = (cls == CLS_OP) && (rs2_a != '0);
  assign rd_we = (cls != CLS_ILLEGAL) && (rd_a != '0);

  // ---- p1: output register towards execute
  logic            vld_p1;
  logic [6:0]      opcode_p1;
  logic [2:0]      funct3_p1;
  logic [6:0]      funct7_p1;
  logic [XLEN-1:0] rs1_p1;
  logic [XLEN-1:0] rs2_p1;
  logic [AW-1:0]   rd_p1;
  logic            rd_we_p1;
  logic [XLEN-1:0] pc_p1;
  logic            illegal_p1;

  logic busy1, busy2, sb_set;

  // A flushed bundle leaving the register must not mark its destination busy.
  assign sb_set = vld_p1 && bus.ex_ready && rd_we_p1 && !flush;

  id_stage_scoreboard #(.REG_NUM(REG_NUM)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (sb_set),
    .set_addr (rd_p1),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .q1_addr  (rs1_a),
    .q2_addr  (rs2_a),
    .q1_busy  (busy1),
    .q2_busy  (busy2)
  );

  logic byp1, byp2, blk1, blk2, hazard, accept;
  assign byp1 = wb_valid && (wb_addr == rs1_a) && (rs1_a != '0);
  assign byp2 = wb_valid && (wb_addr == rs2_a) && (rs2_a != '0);

  // A busy source is released in the very cycle its writeback arrives.
  assign blk1 = (busy1 && !byp1) || (vld_p1 && rd_we_p1 && (rd_p1 == rs1_a));
  assign blk2 = (busy2 && !byp2) || (vld_p1 && rd_we_p1 && (rd_p1 == rs2_a));

  assign hazard       = (use1 && blk1) || (use2 && blk2);
  assign bus.if_ready = !hazard && !flush && (!vld_p1 || bus.ex_ready);
  assign accept       = bus.if_valid && bus.if_ready;

  logic [XLEN-1:0] op1, op2;

  always_comb begin
    op1 = rf_rdata1;
    if (rs1_a == '0) begin
      op1 = '0;
    end else if (byp1) begin
      op1 = wb_data;
    end
    op2 = rf_rdata2;
    if (cls == CLS_OPIMM) begin
      op2 = imm_sx;
    end else if (rs2_a == '0) begin
      op2 = '0;
    end else if (byp2) begin
      op2 = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      opcode_p1  <= '0;
      funct3_p1  <= '0;
      funct7_p1  <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      rd_we_p1   <= 1'b0;
      pc_p1      <= '0;
      illegal_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      opcode_p1  <= opcode;
      funct3_p1  <= funct3;
      funct7_p1  <= funct7;
      rs1_p1     <= op1;
      rs2_p1     <= op2;
      rd_p1      <= rd_a;
      rd_we_p1   <= rd_we;
      pc_p1      <= bus.if_pc;
      illegal_p1 <= (cls == CLS_ILLEGAL);
    end else if (flush || bus.ex_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.ex_valid   = vld_p1;
  assign bus.ex_opcode  = opcode_p1;
  assign bus.ex_funct3  = funct3_p1;
  assign bus.ex_funct7  = funct7_p1;
  assign bus.ex_rs1     = rs1_p1;
  assign bus.ex_rs2     = rs2_p1;
  assign bus.ex_rd_addr = rd_p1;
  assign bus.ex_rd_we   = rd_we_p1;
  assign bus.ex_pc      = pc_p1;
  assign bus.ex_illegal = illegal_p1;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with a small register-file model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic [31:0] rf_mem [32];

  always #5 clk = ~clk;

  id_stage_if bus ();

  id_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flush     (flush)
  );

  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_inst  = '0;
    bus.if_pc    = '0;
    bus.ex_ready = 1'b1;
    wb_valid     = 1'b0;
    wb_addr      = '0;
    wb_data      = '0;
    flush        = 1'b0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + i;
    rf_mem[0] = 32'hDEADBEEF;
    rf_mem[1] = 32'd5;
    rf_mem[2] = 32'd7;
    rf_mem[6] = 32'h60;

    // reset
    repeat (3) tick;
    chk("rst_ex_valid", bus.ex_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_busy", dut.u_sb.busy_q, 0);
    chk("rst_if_ready", bus.if_ready, 1);
    chk("rst_ex_rs1", bus.ex_rs1, 0);
    chk("rst_illegal", bus.ex_illegal, 0);

    // add x3,x1,x2 then back-to-back addi / srai
    present(32'h002081B3, 32'h100);
    #1 chk("add_if_ready", bus.if_ready, 1);
    tick;
    chk("add_valid", bus.ex_valid, 1);
    chk("add_opcode", bus.ex_opcode, 32'h33);
    chk("add_funct3", bus.ex_funct3, 0);
    chk("add_funct7", bus.ex_funct7, 0);
    chk("add_rs1", bus.ex_rs1, 5);
    chk("add_rs2", bus.ex_rs2, 7);
    chk("add_rd", bus.ex_rd_addr, 3);
    chk("add_we", bus.ex_rd_we, 1);
    chk("add_pc", bus.ex_pc, 32'h100);
    present(32'hFFF00293, 32'h104);
    #1 chk("addi_if_ready", bus.if_ready, 1);
    tick;
    chk("addi_rs1", bus.ex_rs1, 0);
    chk("addi_rs2", bus.ex_rs2, 32'hFFFFFFFF);
    chk("addi_funct7", bus.ex_funct7, 0);
    chk("addi_rd", bus.ex_rd_addr, 5);
    chk("addi_busy", dut.u_sb.busy_q, 32'h8);
    present(32'h40435313, 32'h108);
    tick;
    chk("srai_funct7", bus.ex_funct7, 32'h20);
    chk("srai_rs2", bus.ex_rs2, 32'h404);
    chk("srai_rs1", bus.ex_rs1, 32'h60);
    chk("srai_funct3", bus.ex_funct3, 5);
    chk("srai_rd", bus.ex_rd_addr, 6);
    bus.if_valid = 1'b0;
    tick;
    chk("drain_valid", bus.ex_valid, 0);
    chk("drain_busy", dut.u_sb.busy_q, 32'h68);
    wb_valid = 1'b1;
    wb_addr  = 5'd5;
    tick;
    wb_addr = 5'd6;
    tick;
    wb_addr = 5'd3;
    tick;
    wb_valid = 1'b0;
    chk("wb_clear_busy", dut.u_sb.busy_q, 0);

    // RAW: sub x4,x3,x1 behind add x3
    present(32'h002081B3, 32'h10C);
    tick;
    chk("raw_prod_rd", bus.ex_rd_addr, 3);
    present(32'h40118233, 32'h110);
    #1 chk("raw_blk_exreg", bus.if_ready, 0);
    tick;
    chk("raw_gap_valid", bus.ex_valid, 0);
    chk("raw_busy3", dut.u_sb.busy_q, 32'h8);
    chk("raw_blk_busy", bus.if_ready, 0);
    tick;
    chk("raw_blk_busy2", bus.if_ready, 0);
    wb_valid = 1'b1;
    wb_addr  = 5'd3;
    wb_data  = 32'h10;
    #1 chk("raw_wb_ready", bus.if_ready, 1);
    tick;
    wb_valid     = 1'b0;
    bus.if_valid = 1'b0;
    chk("raw_valid", bus.ex_valid, 1);
    chk("raw_rs1_bypass", bus.ex_rs1, 32'h10);
    chk("raw_rs2", bus.ex_rs2, 5);
    chk("raw_funct7", bus.ex_funct7, 32'h20);
    chk("raw_rd", bus.ex_rd_addr, 4);
    chk("raw_pc", bus.ex_pc, 32'h110);
    chk("raw_busy_clr", dut.u_sb.busy_q, 0);
    tick;
    chk("raw_busy4", dut.u_sb.busy_q, 32'h10);

    // backpressure then flush
    bus.ex_ready = 1'b0;
    present(32'h002083B3, 32'h114);
    tick;
    present(32'hFFF00293, 32'h118);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", bus.ex_valid, 1);
      chk("bp_rd", bus.ex_rd_addr, 7);
      chk("bp_rs2", bus.ex_rs2, 7);
      chk("bp_pc", bus.ex_pc, 32'h114);
      chk("bp_if_ready", bus.if_ready, 0);
      tick;
    end
    bus.if_valid = 1'b0;
    flush        = 1'b1;
    #1 chk("flush_if_ready", bus.if_ready, 0);
    tick;
    flush = 1'b0;
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_busy", dut.u_sb.busy_q, 32'h10);
    bus.ex_ready = 1'b1;
    wb_valid     = 1'b1;
    wb_addr      = 5'd4;
    tick;
    wb_valid = 1'b0;
    chk("flush_wb_busy", dut.u_sb.busy_q, 0);

    // illegal opcode
    present(32'h0000007F, 32'h200);
    #1 chk("ill_if_ready", bus.if_ready, 1);
    tick;
    bus.if_valid = 1'b0;
    chk("ill_valid", bus.ex_valid, 1);
    chk("ill_flag", bus.ex_illegal, 1);
    chk("ill_we", bus.ex_rd_we, 0);
    chk("ill_opcode", bus.ex_opcode, 32'h7F);
    tick;
    chk("ill_drain", bus.ex_valid, 0);
    chk("ill_busy", dut.u_sb.busy_q, 0);

    // issue and writeback of the same register in one cycle: set wins
    present(32'h002081B3, 32'h300);
    tick;
    bus.if_valid = 1'b0;
    wb_valid     = 1'b1;
    wb_addr      = 5'd3;
    wb_data      = 32'h0;
    tick;
    wb_valid = 1'b0;
    chk("setwins_busy", dut.u_sb.busy_q, 32'h8);
    wb_valid = 1'b1;
    tick;
    wb_valid = 1'b0;
    chk("setwins_clr", dut.u_sb.busy_q, 0);

    // rd = x0 is never written
    present(32'h00208033, 32'h304);
    tick;
    bus.if_valid = 1'b0;
    chk("x0_valid", bus.ex_valid, 1);
    chk("x0_we", bus.ex_rd_we, 0);
    tick;
    chk("x0_busy", dut.u_sb.busy_q, 0);

    // asynchronous reset mid-operation
    present(32'h002081B3, 32'h308);
    tick;
    present(32'hFFF00293, 32'h30C);
    tick;
    bus.if_valid = 1'b0;
    chk("arst_pre_busy", dut.u_sb.busy_q, 32'h8);
    chk("arst_pre_valid", bus.ex_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.ex_valid, 0);
    chk("arst_busy", dut.u_sb.busy_q, 0);
    chk("arst_rs2", bus.ex_rs2, 0);
    chk("arst_rd", bus.ex_rd_addr, 0);
    rst_n = 1'b1;
    tick;
    chk("arst_if_ready", bus.if_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
